datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001: clk  input  1  single clock; all state updates on its rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: datapath_in  input  16  external value; source for register write-back (vsel=1) and for the immediate on B side (bsel=1).
REQ-004: vsel  input  1  write-back select: 1 = datapath_in, 0 = register C.
REQ-005: writenum  input  3  register-file write address (R0..R7).
REQ-006: write  input  1  register-file write enable.
REQ-007: readnum  input  3  register-file read address.
REQ-008: loada  input  1  load enable, pipeline register A.
REQ-009: loadb  input  1  load enable, pipeline register B.
REQ-010: shift  input  2  shifter op on B: 00 none, 01 LSL#1, 10 LSR#1, 11 ASR#1.
REQ-011: asel  input  1  ALU A-operand select: 1 = 16'd0, 0 = register A.
REQ-012: bsel  input  1  ALU B-operand select: 1 = {11'b0, datapath_in[4:0]}, 0 = shifter output.
REQ-013: ALUop  input  2  00 add, 01 subtract (A-B), 10 bitwise AND, 11 bitwise NOT B.
REQ-014: loadc  input  1  load enable, result register C.
REQ-015: loads  input  1  load enable, status register.
REQ-016: Z_out  output  1  status zero flag.
REQ-017: datapath_out  output  16  contents of register C.

Function
REQ-018: Register file SHALL hold eight 16-bit registers; on rising clk with write=1, R[writenum] <= (vsel ? datapath_in : C).
REQ-019: Register-file read SHALL be combinational: internal signal data_out = R[readnum], no latency.
REQ-020: A <= data_out when loada=1; B <= data_out when loadb=1; otherwise hold; both may load in the same cycle.
REQ-021: Shifter SHALL be combinational: LSL fills bit0 with 0; LSR fills bit15 with 0; ASR replicates bit15.
REQ-022: ALU SHALL be combinational, 16-bit, modulo 2^16; carry/borrow discarded (0xFFFF+1=0x0000, 0-1=0xFFFF).
REQ-023: C <= ALU result when loadc=1; Z <= (ALU result == 0) when loads=1; each holds otherwise.
REQ-024: Z_out = Z register; datapath_out = C register; no combinational path from inputs to outputs.
REQ-025: Simultaneous read and write of same register: data_out shows old value until the edge, new value after.
REQ-026: write with vsel=0 and loadc=1 in the same cycle: register receives the pre-edge C value.
REQ-027: Result register and write-back each take one clk edge; an op from register file to R[n] takes 4 edges (load B, load A, load C, write).

Reset
REQ-028: reset=1 at a rising edge SHALL clear A, B, C and Z to 0, overriding all load/write enables in that cycle.
REQ-029: After reset, datapath_out=16'd0 and Z_out=0.

Configuration
REQ-030: Macro DATAPATH_REGFILE_RESET_EN defined: reset also clears R0..R7 to 0.
REQ-031: Macro undefined: reset does not affect register-file contents (holds prior values, X after power-up).

Structure
REQ-032: Package datapath_pkg SHALL hold data width (16), register count (8), and ALUop and shift encodings.
REQ-033: Register file SHALL be a sub-module named regfile (ports: clk, reset, data_in, writenum, write, readnum, data_out); shifter, ALU, muxes and pipeline registers stay inline.

Verification
REQ-034: Write R0=7, R1=2 (vsel=1); load B=R0, A=R1; shift=01, asel=0, bsel=0, ALUop=00, loadc=1; write R2 with vsel=0; readnum=2 -> data_out=16, datapath_out=16.
REQ-035: A=B=R0=7, shift=00, ALUop=01, loadc=1, loads=1 -> datapath_out=0, Z_out=1; then ALUop=00 -> datapath_out=14, Z_out=0.
REQ-036: B=0x8002; shift=10 then 11 with asel=1, ALUop=00 -> C=0x4001 then 0xC001.
REQ-037: asel=1, bsel=1, datapath_in=16'hFFF3, ALUop=00 -> C=0x0013; ALUop=11 -> C=0xFFEC.
REQ-038: A=0xFFFF, B=0x0001, ALUop=00, loads=1 -> C=0x0000, Z_out=1; ALUop=10 with A=0xF0F0, B=0x0FF0 -> C=0x00F0.
REQ-039: Load C=5, Z=1, then reset=1 with loadc=1 for one edge -> datapath_out=0, Z_out=0; with DATAPATH_REGFILE_RESET_EN, R0..R7 read 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared widths, encodings and helpers for the datapath slice.
// Optional build macro: DATAPATH_REGFILE_RESET_EN (reset also clears R0..R7).
package datapath_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_COUNT = 8;
    localparam int ADDR_W    = 3;
    localparam int IMM_W     = 5;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_e;

    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/datapath_regfile.sv
// Eight-entry register file: synchronous write, combinational read.
// With DATAPATH_REGFILE_RESET_EN defined, reset also clears every entry.
module regfile
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] regs_r [REG_COUNT];

`ifdef DATAPATH_REGFILE_RESET_EN
    // Register storage, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (write) begin
            regs_r[writenum] <= data_in;
        end
    end
`else
    logic unused_reset_s;
    assign unused_reset_s = reset;

    // Register storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (write) begin
            regs_r[writenum] <= data_in;
        end
    end
`endif

    // Read returns the pre-edge value when the same entry is being written.
    assign data_out = regs_r[readnum];

endmodule

// File: rtl/datapath.sv
// Datapath top: register file, A/B pipeline registers, shifter, ALU, C and Z.
// Optional build macro: DATAPATH_REGFILE_RESET_EN (forwarded to the register file).
module datapath
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] datapath_in,
    input  logic              vsel,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum,
    input  logic              loada,
    input  logic              loadb,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [1:0]        ALUop,
    input  logic              loadc,
    input  logic              loads,
    output logic              Z_out,
    output logic [DATA_W-1:0] datapath_out
);

    logic [DATA_W-1:0] a_r, b_r, c_r;
    logic              z_r;
    logic [DATA_W-1:0] data_out_s, wb_data_s;
    logic [DATA_W-1:0] shift_out_s, ain_s, bin_s, alu_out_s;

    // Write-back taps C before the edge, so a same-cycle loadc is not seen.
    assign wb_data_s = vsel ? datapath_in : c_r;

    regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .data_in  (wb_data_s),
        .writenum (writenum),
        .write    (write),
        .readnum  (readnum),
        .data_out (data_out_s)
    );

    // Single-position shifter on operand B.
    always_comb begin
        shift_out_s = b_r;
        case (shift)
            SH_NONE: shift_out_s = b_r;
            SH_LSL:  shift_out_s = {b_r[DATA_W-2:0], 1'b0};
            SH_LSR:  shift_out_s = {1'b0, b_r[DATA_W-1:1]};
            SH_ASR:  shift_out_s = {b_r[DATA_W-1], b_r[DATA_W-1:1]};
            default: shift_out_s = b_r;
        endcase
    end

    // ALU operand selection; the immediate is the low five bits of datapath_in.
    always_comb begin
        ain_s = a_r;
        bin_s = shift_out_s;
        if (asel) begin
            ain_s = {DATA_W{1'b0}};
        end else begin
            ain_s = a_r;
        end
        if (bsel) begin
            bin_s = {{(DATA_W-IMM_W){1'b0}}, datapath_in[IMM_W-1:0]};
        end else begin
            bin_s = shift_out_s;
        end
    end

    // Modulo-2^16 ALU; carry and borrow are dropped.
    always_comb begin
        alu_out_s = {DATA_W{1'b0}};
        case (ALUop)
            ALU_ADD: alu_out_s = ain_s + bin_s;
            ALU_SUB: alu_out_s = ain_s - bin_s;
            ALU_AND: alu_out_s = ain_s & bin_s;
            ALU_NOT: alu_out_s = ~bin_s;
            default: alu_out_s = {DATA_W{1'b0}};
        endcase
    end

    // Pipeline, result and status registers; reset wins over every load.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= {DATA_W{1'b0}};
            b_r <= {DATA_W{1'b0}};
            c_r <= {DATA_W{1'b0}};
            z_r <= 1'b0;
        end else begin
            if (loada) a_r <= data_out_s;
            if (loadb) b_r <= data_out_s;
            if (loadc) c_r <= alu_out_s;
            if (loads) z_r <= is_zero(alu_out_s);
        end
    end

    assign datapath_out = c_r;
    assign Z_out        = z_r;

endmodule

// File: tb/tb_datapath.sv
// Directed, scoreboard-driven bench for the datapath top.
// Honours DATAPATH_REGFILE_RESET_EN for the register-file-after-reset expectation.
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] datapath_in;
    logic        vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic        Z_out;
    logic [15:0] datapath_out;

    typedef struct {
        string       tag;
        logic [15:0] c;
        logic        chk_z;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    datapath dut (
        .clk          (clk),
        .reset        (reset),
        .datapath_in  (datapath_in),
        .vsel         (vsel),
        .writenum     (writenum),
        .write        (write),
        .readnum      (readnum),
        .loada        (loada),
        .loadb        (loadb),
        .shift        (shift),
        .asel         (asel),
        .bsel         (bsel),
        .ALUop        (ALUop),
        .loadc        (loadc),
        .loads        (loads),
        .Z_out        (Z_out),
        .datapath_out (datapath_out)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reset = 1'b0; datapath_in = 16'h0000; vsel = 1'b0; writenum = 3'd0;
        write = 1'b0; readnum = 3'd0; loada = 1'b0; loadb = 1'b0;
        shift = 2'b00; asel = 1'b0; bsel = 1'b0; ALUop = 2'b00;
        loadc = 1'b0; loads = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] c,
                        input logic chk_z, input logic z);
        exp_t e;
        e.tag = tag; e.c = c; e.chk_z = chk_z; e.z = z;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        total++;
        assert (sb.size() > 0) passed++;
        else $error("FAIL scoreboard: observed empty queue expected an entry");
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (datapath_out === e.c) passed++;
            else $error("FAIL %s: datapath_out observed %h expected %h", e.tag, datapath_out, e.c);
            if (e.chk_z) begin
                total++;
                assert (Z_out === e.z) passed++;
                else $error("FAIL %s: Z_out observed %b expected %b", e.tag, Z_out, e.z);
            end
        end
    endtask

    task automatic wr(input logic [2:0] n, input logic [15:0] v);
        idle(); write = 1'b1; vsel = 1'b1; writenum = n; datapath_in = v;
        tick();
    endtask

    task automatic ld(input logic [2:0] n, input logic la, input logic lb);
        idle(); readnum = n; loada = la; loadb = lb;
        tick();
    endtask

    // Drives one loadc cycle, records the expected result and checks it after the edge.
    task automatic op(input string tag, input logic [1:0] sh, input logic as,
                      input logic bs, input logic [1:0] aop, input logic ls,
                      input logic [15:0] din, input logic [15:0] exp_c,
                      input logic exp_z);
        idle(); shift = sh; asel = as; bsel = bs; ALUop = aop;
        loads = ls; datapath_in = din; loadc = 1'b1;
        push(tag, exp_c, ls, exp_z);
        tick();
        check_front();
    endtask

    logic [15:0] exp_r0;
    logic [15:0] exp_r5;

    initial begin
        idle();
        reset = 1'b1;
        push("reset_state", 16'h0000, 1'b1, 1'b0);
        tick();
        check_front();

        // Register file to R2 through the full pipeline.
        wr(3'd0, 16'd7);
        wr(3'd1, 16'd2);
        ld(3'd0, 1'b0, 1'b1);
        ld(3'd1, 1'b1, 1'b0);
        op("add_lsl", 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 16'd16, 1'b0);
        idle(); write = 1'b1; vsel = 1'b0; writenum = 3'd2;
        tick();
        ld(3'd2, 1'b0, 1'b1);
        op("r2_readback", 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'd32, 1'b0);

        // Write-back of C while C is being reloaded takes the old C.
        idle(); write = 1'b1; vsel = 1'b0; writenum = 3'd3;
        asel = 1'b1; bsel = 1'b1; datapath_in = 16'd5; loadc = 1'b1;
        push("wb_with_loadc", 16'd5, 1'b0, 1'b0);
        tick();
        check_front();
        ld(3'd3, 1'b0, 1'b1);
        op("r3_old_c", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'd32, 1'b0);

        // Read and write of the same entry in one cycle.
        wr(3'd4, 16'h0AAA);
        idle(); write = 1'b1; vsel = 1'b1; writenum = 3'd4; datapath_in = 16'h1234;
        readnum = 3'd4; loadb = 1'b1;
        tick();
        op("rw_same_old", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0AAA, 1'b0);
        ld(3'd4, 1'b0, 1'b1);
        op("rw_same_new", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h1234, 1'b0);

        // Subtract to zero, then add.
        ld(3'd0, 1'b1, 1'b1);
        op("sub_zero", 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0000, 16'h0000, 1'b1);
        op("add_14", 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 16'd14, 1'b0);

        // Shifter modes on 0x8002.
        wr(3'd5, 16'h8002);
        ld(3'd5, 1'b0, 1'b1);
        op("lsr", 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h4001, 1'b0);
        op("asr", 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'hC001, 1'b0);
        op("lsl", 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0004, 1'b0);

        // Immediate operand and NOT.
        op("imm_add", 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 16'hFFF3, 16'h0013, 1'b0);
        op("imm_not", 2'b00, 1'b1, 1'b1, 2'b11, 1'b1, 16'hFFF3, 16'hFFEC, 1'b0);

        // Wrap-around, borrow and AND.
        wr(3'd6, 16'hFFFF);
        wr(3'd7, 16'h0001);
        ld(3'd6, 1'b1, 1'b0);
        ld(3'd7, 1'b0, 1'b1);
        op("add_wrap", 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 16'h0000, 1'b1);
        op("sub_borrow", 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
        wr(3'd6, 16'hF0F0);
        wr(3'd7, 16'h0FF0);
        ld(3'd6, 1'b1, 1'b0);
        ld(3'd7, 1'b0, 1'b1);
        op("and", 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 16'h00F0, 1'b0);

        // Z set, C reloaded without loads, then a hold cycle.
        op("imm_zero", 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000, 16'h0000, 1'b1);
        idle(); asel = 1'b1; bsel = 1'b1; datapath_in = 16'd5; loadc = 1'b1;
        push("c5_z_hold", 16'd5, 1'b1, 1'b1);
        tick();
        check_front();
        idle();
        push("idle_hold", 16'd5, 1'b1, 1'b1);
        tick();
        check_front();

        // Reset overrides all loads.
        idle(); reset = 1'b1; readnum = 3'd0; loada = 1'b1; loadb = 1'b1;
        loadc = 1'b1; loads = 1'b1; asel = 1'b1; bsel = 1'b1; datapath_in = 16'd7;
        push("reset_override", 16'h0000, 1'b1, 1'b0);
        tick();
        check_front();
        op("ab_cleared", 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 16'h0000, 1'b1);

`ifdef DATAPATH_REGFILE_RESET_EN
        exp_r0 = 16'h0000;
        exp_r5 = 16'h0000;
`else
        exp_r0 = 16'd7;
        exp_r5 = 16'h8002;
`endif
        ld(3'd0, 1'b0, 1'b1);
        op("r0_after_reset", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, exp_r0, 1'b0);
        ld(3'd5, 1'b0, 1'b1);
        op("r5_after_reset", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, exp_r5, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
